alu_pipelined: RTL
==================

Name: alu_pipelined

Overview:
Parametrised, two-stage registered successor to the combinational 8-bit ALU. Accepts operands and a MIPS-style funct opcode under a valid/ready handshake. Returns a registered result plus status flags with backpressure support. Sits between the operand-capture/control logic and the display/datapath consumer.

Parameters:
NB_DATA, 8, operand and result width (>=4, power of 2).
NB_OP, 6, opcode width (funct field).
NB_SHAMT, $clog2(NB_DATA), shift-amount bits taken from i_dato_b LSBs.

Ports:
i_clk  in  1  single clock; all logic on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_valid  in  1  input transaction present.
o_ready  out  1  block can accept input this cycle.
i_dato_a  in  NB_DATA  operand A.
i_dato_b  in  NB_DATA  operand B / shift amount.
i_operation  in  NB_OP  funct opcode.
o_valid  out  1  result present.
i_ready  in  1  downstream accepts result.
o_result  out  NB_DATA  registered result.
o_zero  out  1  result == 0.
o_negative  out  1  result MSB.
o_carry  out  1  ADD carry-out / SUB borrow.
o_overflow  out  1  signed overflow, ADD/SUB only.
o_invalid_op  out  1  unsupported opcode.

Behaviour:
- Reset: o_valid, o_result, all flags = 0; both stage-valid bits cleared; o_ready = 0 while i_reset high.
- Stage 1 (S1) registers a, b, and op on acceptance (i_valid && o_ready).
- Stage 2 (S2) registers the core output and flags.
- Latency: exactly 2 cycles from accept edge to o_valid, with no stall.
- Throughput: 1 transaction/cycle.
- Stall rules:
  - s2_adv = !o_valid || i_ready.
  - s1_adv = !s1_valid || s2_adv.
  - o_ready = s1_adv (combinational, not in reset).
- While o_valid && !i_ready: o_result and flags hold stable.
- If S1 empties without a new accept, its valid bit clears; S2 clears o_valid when it advances with an empty S1.
- Ordering is strictly preserved. No transaction is dropped or duplicated.
- Opcodes:
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SRL 000010: logical right shift of a by b[NB_SHAMT-1:0].
  - SRA 000011: arithmetic right shift of a by b[NB_SHAMT-1:0].
- Arithmetic: modulo 2^NB_DATA. Compute in NB_DATA+1 bits; MSB gives carry.
  - SUB carry = 1 when a < b unsigned.
  - Overflow on ADD: sign(a)==sign(b) && sign(r)!=sign(a).
  - Overflow on SUB: sign(a)!=sign(b) && sign(r)!=sign(a).
  - carry and overflow = 0 for all other ops.
- Invalid opcode: result 0, o_zero=1, o_invalid_op=1, other flags 0. The transaction still flows normally.
- Reset mid-operation discards both stages. The next cycle shows o_valid=0, and o_ready=1 once reset drops.
- Simultaneous accept and output-consume in the same cycle is legal at full rate.

Optional Feature:
ALU_SLT_EN.
- Defined: adds SLT 101010 (signed a<b -> 1 else 0, zero-extended) and SLTU 101011 (unsigned compare). Flags follow the result, with carry=overflow=0.
- Undefined: 101010 and 101011 are treated as invalid opcodes.

Decomposition:
- Shared header alu_defs.vh holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA, OP_SLT, OP_SLTU.
  - flag index constants.
- One sub-module, alu_core: purely combinational, parametrised by NB_DATA. It takes a, b, and op and returns result, carry, overflow, and invalid.
- alu_pipelined owns the S1/S2 registers, the handshake, and the zero/negative derivation.

Test Plan:
- ADD a=0x7F, b=0x01, single valid -> 2 cycles later o_valid=1, o_result=0x80, overflow=1, negative=1, carry=0, zero=0.
- SUB a=0x01, b=0x02 -> 0xFF, carry=1, negative=1, overflow=0. Then AND a=0xF0, b=0x0F -> 0x00, zero=1. Then NOR 0x00,0x00 -> 0xFF.
- SRA a=0x80, b=0x03 -> 0xF0. SRL a=0x80, b=0x03 -> 0x10. Shift b=0x0B (8-bit) uses only shamt 3 -> same results.
- Backpressure: hold i_ready=0 and drive 4 back-to-back valid ADDs (1+1, 2+2, 3+3, 4+4).
  - Exactly 2 are accepted, then o_ready=0; o_result=0x02 stays stable.
  - Release i_ready -> 0x02, 0x04, 0x06, 0x08 in order, none lost.
- Opcode 6'b111111 -> o_result=0, o_invalid_op=1, zero=1. Opcode 101010 with a=0xFF, b=0x01 -> 0x01 with ALU_SLT_EN, invalid without it.
- Assert i_reset for 1 cycle with both stages full -> o_valid=0 and all outputs 0 next cycle; o_ready=1 once reset deasserts; the next transaction has 2-cycle latency.

Source files
------------

// File: rtl/alu_pipelined_pkg.sv
// Shared opcode encodings and flag-vector layout for the pipelined ALU.
// OP_SLT/OP_SLTU are decoded only when ALU_SLT_EN is defined.
package alu_pipelined_pkg;

    localparam int OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'b100000;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'b100010;
    localparam logic [OPCODE_W-1:0] OP_AND  = 6'b100100;
    localparam logic [OPCODE_W-1:0] OP_OR   = 6'b100101;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 6'b100110;
    localparam logic [OPCODE_W-1:0] OP_NOR  = 6'b100111;
    localparam logic [OPCODE_W-1:0] OP_SRL  = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_SRA  = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_SLT  = 6'b101010;
    localparam logic [OPCODE_W-1:0] OP_SLTU = 6'b101011;

    // Bit positions inside the registered flag vector.
    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_NEGATIVE = 1;
    localparam int FLAG_CARRY    = 2;
    localparam int FLAG_OVERFLOW = 3;
    localparam int FLAG_INVALID  = 4;
    localparam int NB_FLAGS      = 5;

endpackage

// File: rtl/alu_pipelined_core.sv
// Combinational ALU datapath: result plus carry/overflow/invalid for one operand set.
// Macro ALU_SLT_EN adds the SLT/SLTU compares; otherwise those opcodes decode as invalid.
module alu_core
    import alu_pipelined_pkg::*;
#(
    parameter int NB_DATA  = 8,
    parameter int NB_OP    = 6,
    parameter int NB_SHAMT = $clog2(NB_DATA)
) (
    input  logic [NB_DATA-1:0] a_i,
    input  logic [NB_DATA-1:0] b_i,
    input  logic [NB_OP-1:0]   op_i,
    output logic [NB_DATA-1:0] result_o,
    output logic               carry_o,
    output logic               overflow_o,
    output logic               invalid_o
);

    localparam int MSB = NB_DATA - 1;

    logic [NB_DATA:0]    sum;
    logic [NB_DATA:0]    diff;
    logic [NB_SHAMT-1:0] shamt;

    // The extra top bit is carry on ADD and borrow (a < b unsigned) on SUB.
    assign sum   = {1'b0, a_i} + {1'b0, b_i};
    assign diff  = {1'b0, a_i} - {1'b0, b_i};
    assign shamt = b_i[NB_SHAMT-1:0];

    always_comb begin
        result_o   = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        invalid_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o   = sum[NB_DATA-1:0];
                carry_o    = sum[NB_DATA];
                overflow_o = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                result_o   = diff[NB_DATA-1:0];
                carry_o    = diff[NB_DATA];
                overflow_o = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_NOR: result_o = ~(a_i | b_i);
            OP_SRL: result_o = a_i >> shamt;
            OP_SRA: result_o = $signed(a_i) >>> shamt;
`ifdef ALU_SLT_EN
            OP_SLT:  result_o = {{(NB_DATA-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: result_o = {{(NB_DATA-1){1'b0}}, (a_i < b_i)};
`endif
            default: invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipelined.sv
// Two-stage ALU with valid/ready on both sides: S1 captures operands, S2 holds result and flags.
// Macro ALU_SLT_EN (passed through to alu_core) enables the SLT/SLTU opcodes.
module alu_pipelined
    import alu_pipelined_pkg::*;
#(
    parameter int NB_DATA  = 8,
    parameter int NB_OP    = 6,
    parameter int NB_SHAMT = $clog2(NB_DATA)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_dato_a,
    input  logic [NB_DATA-1:0] i_dato_b,
    input  logic [NB_OP-1:0]   i_operation,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero,
    output logic               o_negative,
    output logic               o_carry,
    output logic               o_overflow,
    output logic               o_invalid_op
);

    logic               s1_valid_q, s1_valid_d;
    logic [NB_DATA-1:0] s1_a_q, s1_a_d;
    logic [NB_DATA-1:0] s1_b_q, s1_b_d;
    logic [NB_OP-1:0]   s1_op_q, s1_op_d;

    logic                s2_valid_q, s2_valid_d;
    logic [NB_DATA-1:0]  s2_result_q, s2_result_d;
    logic [NB_FLAGS-1:0] s2_flags_q, s2_flags_d;

    logic               s2_adv;
    logic               s1_adv;
    logic               accept;

    logic [NB_DATA-1:0] core_result;
    logic               core_carry;
    logic               core_overflow;
    logic               core_invalid;

    alu_core #(
        .NB_DATA  (NB_DATA),
        .NB_OP    (NB_OP),
        .NB_SHAMT (NB_SHAMT)
    ) u_core (
        .a_i        (s1_a_q),
        .b_i        (s1_b_q),
        .op_i       (s1_op_q),
        .result_o   (core_result),
        .carry_o    (core_carry),
        .overflow_o (core_overflow),
        .invalid_o  (core_invalid)
    );

    // S2 frees up when empty or being consumed; S1 frees up when empty or moving into S2.
    assign s2_adv  = !s2_valid_q || i_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign o_ready = s1_adv && !i_reset;
    assign accept  = i_valid && o_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_adv) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_a_d  = i_dato_a;
            s1_b_d  = i_dato_b;
            s1_op_d = i_operation;
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d                = core_result;
                s2_flags_d[FLAG_ZERO]      = (core_result == '0);
                s2_flags_d[FLAG_NEGATIVE]  = core_result[NB_DATA-1];
                s2_flags_d[FLAG_CARRY]     = core_carry;
                s2_flags_d[FLAG_OVERFLOW]  = core_overflow;
                s2_flags_d[FLAG_INVALID]   = core_invalid;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
        end
    end

    assign o_valid      = s2_valid_q;
    assign o_result     = s2_result_q;
    assign o_zero       = s2_flags_q[FLAG_ZERO];
    assign o_negative   = s2_flags_q[FLAG_NEGATIVE];
    assign o_carry      = s2_flags_q[FLAG_CARRY];
    assign o_overflow   = s2_flags_q[FLAG_OVERFLOW];
    assign o_invalid_op = s2_flags_q[FLAG_INVALID];

endmodule
